// File: rtl/memory_write.sv
`default_nettype none
// ============================================================================
// Module   : memory_write
// Purpose  : Write-back stage. Takes a buffer of NWORDS words and a base
//            address on a Start/Ready handshake. Writes the words to memory
//            one per cycle at consecutive addresses. MemWait applies
//            back-pressure. done_vld pulses for one cycle when the transfer
//            completes.
// Ports    :
//   Clk       in   clock, rising edge
//   Rst_n     in   asynchronous active-low reset
//   Start     in   request to write a buffer (accepted when Ready=1)
//   AddrIn    in   base address, sampled with accepted Start
//   DataBuff  in   buffer; word i = DataBuff[DATA_W*i +: DATA_W]
//   MemWait   in   memory busy; the presented write is held while high
//   Ready     out  high in IDLE only
//   Addr      out  memory write address
//   DataIn    out  memory write data
//   WR        out  write strobe
//   done_vld  out  one-cycle completion pulse
// Revision : 1.0  initial release
// ============================================================================
module memory_write #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NWORDS = 16
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Start,
  input  logic [ADDR_W-1:0]          AddrIn,
  input  logic [DATA_W*NWORDS-1:0]   DataBuff,
  input  logic                       MemWait,
  output logic                       Ready,
  output logic [ADDR_W-1:0]          Addr,
  output logic [DATA_W-1:0]          DataIn,
  output logic                       WR,
  output logic                       done_vld
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [IDX_W-1:0]           r_idx, w_idx_nxt, w_idx_inc;
  logic [ADDR_W-1:0]          r_base, w_base_nxt;
  logic [DATA_W*NWORDS-1:0]   r_shadow, w_shadow_nxt;
  logic [ADDR_W-1:0]          w_addr_nxt;
  logic [DATA_W-1:0]          w_data_nxt;
  logic                       w_wr_nxt;
  logic                       w_done_nxt;
  logic                       w_ready_nxt;

  assign w_idx_inc = r_idx + IDX_W'(1);

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the values the outputs take after the coming edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_base_nxt   = r_base;
    w_shadow_nxt = r_shadow;
    w_addr_nxt   = Addr;
    w_data_nxt   = DataIn;
    w_wr_nxt     = WR;
    w_done_nxt   = 1'b0;
    w_ready_nxt  = Ready;

    case (r_state)
      S_IDLE: begin
        // MemWait is ignored here; it only throttles the WRITE state.
        if (Start && Ready) begin
          w_base_nxt   = AddrIn;
          w_shadow_nxt = DataBuff;
          w_idx_nxt    = '0;
          w_addr_nxt   = AddrIn;
          w_data_nxt   = DataBuff[DATA_W-1:0];
          w_wr_nxt     = 1'b1;
          w_ready_nxt  = 1'b0;
          w_state_nxt  = S_WRITE;
        end
      end

      S_WRITE: begin
        // A word is accepted when WR=1 and MemWait=0; otherwise everything holds.
        if (!MemWait) begin
          if (r_idx == C_LAST_IDX) begin
            w_wr_nxt    = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt  = w_idx_inc;
            // Address wraps modulo 2^ADDR_W by truncation.
            w_addr_nxt = r_base + ADDR_W'(w_idx_inc);
            w_data_nxt = r_shadow[w_idx_inc*DATA_W +: DATA_W];
          end
        end
      end

      S_DONE: begin
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_wr_nxt    = 1'b0;
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_idx    <= '0;
      r_base   <= '0;
      r_shadow <= '0;
      Addr     <= '0;
      DataIn   <= '0;
      WR       <= 1'b0;
      done_vld <= 1'b0;
      Ready    <= 1'b1;
    end else begin
      r_idx    <= w_idx_nxt;
      r_base   <= w_base_nxt;
      r_shadow <= w_shadow_nxt;
      Addr     <= w_addr_nxt;
      DataIn   <= w_data_nxt;
      WR       <= w_wr_nxt;
      done_vld <= w_done_nxt;
      Ready    <= w_ready_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_write
// Purpose  : Self-checking bench for memory_write. Runs a table of transfers
//            and checks each presented write, the completion timing and the
//            handshake. Also covers an asynchronous reset in the middle of a
//            transfer.
// Revision : 1.0  initial release
// ============================================================================
module tb_memory_write;

  logic         Clk;
  logic         Rst_n;
  logic         Start;
  logic [15:0]  AddrIn;
  logic [255:0] DataBuff;
  logic         MemWait;
  logic         Ready;
  logic [15:0]  Addr;
  logic [15:0]  DataIn;
  logic         WR;
  logic         done_vld;

  int total = 0;
  int bad   = 0;

  memory_write dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .AddrIn   (AddrIn),
    .DataBuff (DataBuff),
    .MemWait  (MemWait),
    .Ready    (Ready),
    .Addr     (Addr),
    .DataIn   (DataIn),
    .WR       (WR),
    .done_vld (done_vld)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] dbase;
    int          wait_idx;
    int          wait_n;
    bit          poke;
    bit          start_wait;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_done;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] mk_buf(input logic [15:0] base);
    logic [255:0] b;
    for (int i = 0; i < 16; i++) b[i*16 +: 16] = base + 16'(i);
    return b;
  endfunction

  // Runs one transfer. On entry we are 1 time unit after a rising edge.
  task automatic run_xfer(input vec_t v);
    int          c;
    int          k;
    int          waits_left;
    int          done_c;
    logic [15:0] first_a;
    logic [15:0] last_a;
    logic [15:0] exp_a;
    logic [15:0] exp_d;
    chk("ready_before_start", {31'd0, Ready}, 32'd1);
    Start    = 1'b1;
    AddrIn   = v.addr;
    DataBuff = mk_buf(v.dbase);
    MemWait  = v.start_wait;
    tick();
    Start      = 1'b0;
    MemWait    = 1'b0;
    c          = 1;
    k          = 0;
    waits_left = v.wait_n;
    done_c     = -1;
    first_a    = '0;
    last_a     = '0;
    while (c < 60) begin
      if (done_vld) begin
        done_c = c;
        break;
      end
      Start = 1'b0;
      if (WR) begin
        exp_a = v.addr + 16'(k);
        exp_d = v.dbase + 16'(k);
        chk("wr_addr", {16'd0, Addr}, {16'd0, exp_a});
        chk("wr_data", {16'd0, DataIn}, {16'd0, exp_d});
        chk("ready_low_in_write", {31'd0, Ready}, 32'd0);
        if (k == 0) first_a = Addr;
        last_a = Addr;
        if (v.poke && k == 4) begin
          Start    = 1'b1;
          AddrIn   = 16'h1234;
          DataBuff = mk_buf(16'h5550);
        end
        if (k == v.wait_idx && waits_left > 0) begin
          MemWait = 1'b1;
          waits_left--;
        end else begin
          MemWait = 1'b0;
        end
        if (!MemWait) k++;
      end else begin
        MemWait = 1'b0;
      end
      tick();
      c++;
    end
    MemWait = 1'b0;
    Start   = 1'b0;
    if (done_c < 0) begin
      bad++;
      total++;
      $display("FAIL done_timeout: no done_vld within 60 cycles, words=%0d", k);
    end else begin
      chk("done_cycle", done_c, v.exp_done);
      chk("words_written", k, 16);
      chk("first_addr", {16'd0, first_a}, {16'd0, v.exp_first});
      chk("last_addr", {16'd0, last_a}, {16'd0, v.exp_last});
      chk("wr_low_at_done", {31'd0, WR}, 32'd0);
      chk("ready_low_at_done", {31'd0, Ready}, 32'd0);
      tick();
      chk("done_single_pulse", {31'd0, done_vld}, 32'd0);
      chk("ready_after_done", {31'd0, Ready}, 32'd1);
    end
  endtask

  initial begin
    int k;
    int guard;
    int seen_done;

    //            addr      dbase     widx wn poke sw  first     last      done
    vecs[0] = '{16'h0100, 16'hA000, 0,  0, 1'b0, 1'b0, 16'h0100, 16'h010F, 17};
    vecs[1] = '{16'h0100, 16'hA000, 5,  3, 1'b0, 1'b0, 16'h0100, 16'h010F, 20};
    vecs[2] = '{16'hFFF8, 16'hC000, 0,  0, 1'b0, 1'b0, 16'hFFF8, 16'h0007, 17};
    vecs[3] = '{16'h0300, 16'hD000, 15, 1, 1'b1, 1'b1, 16'h0300, 16'h030F, 18};

    Rst_n    = 1'b0;
    Start    = 1'b0;
    AddrIn   = '0;
    DataBuff = '0;
    MemWait  = 1'b0;
    tick();
    tick();
    chk("rst_ready", {31'd0, Ready}, 32'd1);
    chk("rst_wr", {31'd0, WR}, 32'd0);
    chk("rst_addr", {16'd0, Addr}, 32'd0);
    chk("rst_data", {16'd0, DataIn}, 32'd0);
    chk("rst_done", {31'd0, done_vld}, 32'd0);
    Rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_xfer(vecs[i]);
      tick();
    end

    // Asynchronous reset after word 7 has been accepted.
    Start    = 1'b1;
    AddrIn   = 16'h0200;
    DataBuff = mk_buf(16'hB000);
    tick();
    Start = 1'b0;
    k     = 0;
    guard = 0;
    while (k < 8 && guard < 40) begin
      if (WR) k++;
      tick();
      guard++;
    end
    chk("pre_rst_word8_addr", {16'd0, Addr}, 32'h0208);
    chk("pre_rst_wr", {31'd0, WR}, 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("async_rst_wr", {31'd0, WR}, 32'd0);
    chk("async_rst_addr", {16'd0, Addr}, 32'd0);
    chk("async_rst_data", {16'd0, DataIn}, 32'd0);
    chk("async_rst_done", {31'd0, done_vld}, 32'd0);
    chk("async_rst_ready", {31'd0, Ready}, 32'd1);
    #1;
    Rst_n = 1'b1;
    tick();
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_vld || WR) seen_done++;
      tick();
    end
    chk("no_activity_after_abort", seen_done, 0);
    run_xfer(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
